// File: rtl/bcd_disp_if.sv
// bcd_disp_if: input handshake between the stopwatch counter (master) and
// the BCD display controller (slave).
//   in_valid  master -> slave  in_data holds a value to convert
//   in_data   master -> slave  16-bit unsigned binary value
//   in_ready  slave -> master  controller can accept a new value
interface bcd_disp_if;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/bcd_disp_ctl.sv
// bcd_disp_ctl: converts a 16-bit binary value to four BCD digits with an
// iterative shift-and-add-3 engine (one bit per clock) and scans the latched
// result onto a 4-digit multiplexed 7-segment display.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for in_valid; in_ready high
//   SHIFT  | 16 add-3/shift iterations, cnt counts 15 down to 0
//   LATCH  | publish bcd_word/ovf, pulse done, return to IDLE
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   bus (slave)     in_valid / in_data / in_ready handshake
//   busy            conversion in progress (SHIFT or LATCH)
//   done            one-cycle pulse after bcd_word/ovf update
//   bcd_word, ovf   latched result {d3,d2,d1,d0}; ovf when input > 9999
//   an, digit, blank  scan outputs: active-low anode, selected nibble, blank flag
module bcd_disp_ctl #(
   parameter int unsigned REFRESH_DIV = 100_000,
   parameter bit          BLANK_LZ    = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   bcd_disp_if.slave   bus,
   output logic        busy,
   output logic        done,
   output logic [15:0] bcd_word,
   output logic        ovf,
   output logic [3:0]  an,
   output logic [3:0]  digit,
   output logic        blank
);

   localparam int unsigned DIV_W = $clog2(REFRESH_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

   state_t      state;
   logic        ready_q;
   logic [15:0] shreg;
   logic [15:0] work;
   logic [3:0]  cnt;
   logic        ovf_n;

   logic [DIV_W-1:0] div;
   logic [1:0]       sel;

   // Each BCD nibble above 4 gets +3 before the shift so it carries correctly.
   function automatic logic [15:0] add3(input logic [15:0] w);
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < 4; i++)
         r[4*i +: 4] = (w[4*i +: 4] > 4'd4) ? w[4*i +: 4] + 4'd3 : w[4*i +: 4];
      return r;
   endfunction

   logic [15:0] work_adj;
   assign work_adj    = add3(work);
   assign bus.in_ready = ready_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ready_q  <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         bcd_word <= '0;
         ovf      <= 1'b0;
         shreg    <= '0;
         work     <= '0;
         cnt      <= '0;
         ovf_n    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  shreg   <= bus.in_data;
                  work    <= '0;
                  cnt     <= 4'd15;
                  ovf_n   <= (bus.in_data > 16'd9999);
                  ready_q <= 1'b0;
                  busy    <= 1'b1;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               // Bits shifted out of work only matter for values > 9999,
               // which saturate anyway.
               {work, shreg} <= {work_adj[14:0], shreg, 1'b0};
               cnt <= cnt - 4'd1;
               if (cnt == 4'd0)
                  state <= LATCH;
            end
            LATCH: begin
               bcd_word <= ovf_n ? 16'h9999 : work;
               ovf      <= ovf_n;
               done     <= 1'b1;
               ready_q  <= 1'b1;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               ready_q <= 1'b1;
               busy    <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div <= '0;
         sel <= '0;
      end else if (div == DIV_LAST) begin
         div <= '0;
         sel <= sel + 2'd1;
      end else begin
         div <= div + 1'b1;
      end
   end

   // hi_zero[k]: nibbles k..3 of bcd_word are all zero.
   logic [3:0] hi_zero;
   always_comb begin
      hi_zero    = '0;
      hi_zero[3] = (bcd_word[15:12] == 4'd0);
      hi_zero[2] = hi_zero[3] && (bcd_word[11:8] == 4'd0);
      hi_zero[1] = hi_zero[2] && (bcd_word[7:4] == 4'd0);
      hi_zero[0] = hi_zero[1] && (bcd_word[3:0] == 4'd0);
   end

   // Scan outputs decode only registered sel/bcd_word, so they switch cleanly.
   always_comb begin
      blank = BLANK_LZ && (sel != 2'd0) && hi_zero[sel];
      digit = bcd_word[{sel, 2'b00} +: 4];
      an    = blank ? 4'b1111 : ~(4'b0001 << sel);
   end

endmodule

// File: tb/tb_bcd_disp_ctl.sv
// tb_bcd_disp_ctl: directed bench for bcd_disp_ctl with REFRESH_DIV=4.
module tb_bcd_disp_ctl;
   logic        clk;
   logic        rst_n;
   logic        busy, done, ovf, blank;
   logic [15:0] bcd_word;
   logic [3:0]  an, digit;

   int n_chk  = 0;
   int n_pass = 0;

   bcd_disp_if bus();

   bcd_disp_ctl #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .busy     (busy),
      .done     (done),
      .bcd_word (bcd_word),
      .ovf      (ovf),
      .an       (an),
      .digit    (digit),
      .blank    (blank)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [15:0] ref_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // Caller is at a negedge; accept happens on the next posedge.
   task automatic convert(input logic [15:0] v, input logic [15:0] ew, input logic eo);
      logic [15:0] w0;
      int lat, unstable, idle_gap;
      bus.in_valid = 1'b1;
      bus.in_data  = v;
      chk("ready_pre", 32'(bus.in_ready), 32'd1);
      w0 = bcd_word;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 0; unstable = 0; idle_gap = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         lat++;
         if (done) break;
         if (bcd_word !== w0) unstable++;
         if (!busy) idle_gap++;
      end
      chk("latency", 32'(lat), 32'd17);
      chk("word", 32'(bcd_word), 32'(ew));
      chk("ovf", 32'(ovf), 32'(eo));
      chk("stable", 32'(unstable + idle_gap), 32'd0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
      chk({tag, "_busy"},  32'(busy), 32'd0);
      chk({tag, "_done"},  32'(done), 32'd0);
      chk({tag, "_word"},  32'(bcd_word), 32'd0);
      chk({tag, "_ovf"},   32'(ovf), 32'd0);
      chk({tag, "_an"},    32'(an), 32'hE);
      chk({tag, "_digit"}, 32'(digit), 32'd0);
      chk({tag, "_blank"}, 32'(blank), 32'd0);
   endtask

   logic [3:0] exp_an[4]    = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
   logic [3:0] exp_digit[4] = '{4'd7, 4'd5, 4'd0, 4'd0};
   logic       exp_blank[4] = '{1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      int acc, ndone, both_hi, found;
      int acc_k[2];
      logic [15:0] res[2];
      logic [3:0] an_prev;

      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("rst");

      // Test 1: accept on first edge after reset release.
      @(negedge clk);
      rst_n = 1'b1;
      convert(16'd1234, 16'h1234, 1'b0);
      @(posedge clk); #1;
      chk("done_pulse", 32'(done), 32'd0);

      // Test 2: saturation boundary.
      @(negedge clk); convert(16'd9999,  16'h9999, 1'b0);
      @(negedge clk); convert(16'd10000, 16'h9999, 1'b1);
      @(negedge clk); convert(16'd65535, 16'h9999, 1'b1);

      // Test 3: in_valid held high, data 0 then 42.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'd0;
      acc = 0; ndone = 0; both_hi = 0;
      acc_k[0] = 0; acc_k[1] = 0;
      res[0] = 16'hFFFF; res[1] = 16'hFFFF;
      for (int k = 0; k < 40; k++) begin
         if (bus.in_valid && bus.in_ready) begin
            if (acc < 2) acc_k[acc] = k;
            acc++;
         end
         @(posedge clk); #1;
         if (acc == 1) bus.in_data = 16'd42;
         if (acc >= 2) bus.in_valid = 1'b0;
         if (busy && bus.in_ready) both_hi++;
         if (done) begin
            if (ndone < 2) res[ndone] = bcd_word;
            ndone++;
         end
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      chk("hold_accepts", 32'(acc), 32'd2);
      chk("hold_spacing", 32'(acc_k[1] - acc_k[0]), 32'd18);
      chk("hold_res0", 32'(res[0]), 32'h0000);
      chk("hold_res1", 32'(res[1]), 32'h0042);
      chk("hold_ndone", 32'(ndone), 32'd2);
      chk("hold_ready_busy", 32'(both_hi), 32'd0);

      // Test 4: scan pattern for 0057.
      @(negedge clk); convert(16'd57, 16'h0057, 1'b0);
      found = 0;
      an_prev = an;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (an == 4'b1110 && an_prev == 4'b1111) begin
            found = 1;
            break;
         end
         an_prev = an;
      end
      chk("scan_sync", 32'(found), 32'd1);
      for (int j = 0; j < 20; j++) begin
         if (j != 0) begin
            @(posedge clk); #1;
         end
         chk("scan_an",    32'(an),    32'(exp_an[(j / 4) % 4]));
         chk("scan_digit", 32'(digit), 32'(exp_digit[(j / 4) % 4]));
         chk("scan_blank", 32'(blank), 32'(exp_blank[(j / 4) % 4]));
      end

      // Test 5: reset during SHIFT of 4321.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'd4321;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("mid_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("abort");
      ndone = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      chk("abort_nodone", 32'(ndone), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      convert(16'd4321, 16'h4321, 1'b0);

      // Test 6: sweep of the legal range against the reference.
      for (int v = 0; v < 10000; v += 7) begin
         @(negedge clk);
         convert(16'(v), ref_bcd(v), 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
